cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle control FSM for the 32-bit cs147sec05 processor; sits directly upstream of DATA_PATH.
//  Decodes INSTRUCTION and ZERO from the data path and drives its 32-bit CTRL word.
//  Also drives memory READ/WRITE strobes. Every instruction takes 5 states plus optional memory wait cycles.
// PARAMETERS
//  MEM_WAIT_CYCLES  0  extra cycles held in FETCH and MEMORY for slow memory (0..15)
// PORTS
//  CLK          in   1   clock; all state changes on rising edge
//  RST          in   1   reset; synchronous, active-low
//  INSTRUCTION  in   32  IR contents from data path
//  ZERO         in   1   ALU zero flag from data path
//  CTRL         out  32  data-path control word; bits 31:29 reserved, always 0
//  READ         out  1   memory read strobe
//  WRITE        out  1   memory write strobe
// BEHAVIOUR
//  CTRL map: [0]pc_load [1]pc_sel_1 [2]pc_sel_2 [3]pc_sel_3 [4]ir_load [5]r1_sel_1 [6]reg_r [7]reg_w
//    [8]wa_sel_1 [9]wa_sel_2 [10]wa_sel_3 [11]wd_sel_1 [12]wd_sel_2 [13]wd_sel_3 [14]sp_load
//    [15]op1_sel_1 [16..19]op2_sel_1..4 [25:20]alu_oprn [26]ma_sel_1 [27]ma_sel_2 [28]md_sel_1.
//  alu_oprn encoding: add=1 sub=2 mul=3 shr=4 shl=5 and=6 or=7 nor=8 slt=9.
//  States: RESET, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK. Next state is a pure function of the current state and the wait counter.
//  RST=0 at an edge forces RESET from any state, clears the wait counter and zeroes all outputs.
//    - No partial writes: reg_w, sp_load, pc_load and WRITE are all 0 in RESET.
//  Sequence: RESET -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH, with RST=1.
//  Wait counter: loads MEM_WAIT_CYCLES on entry to FETCH and to MEMORY. The state holds while the counter is nonzero.
//    - The counter decrements each cycle while holding.
//    - MEM_WAIT_CYCLES=0 gives exactly 1 cycle per state.
//  Outputs are combinational from the registered state and INSTRUCTION; no added latency.
//  FETCH: READ=1 and ma_sel_2=1 (ADDR=PC); everything else 0.
//  DECODE: READ=1, ma_sel_2=1, ir_load=1 (IR captures on exit edge); reg_r=1.
//  EXECUTE: reg_r=1; alu_oprn and operand selects decoded from opcode/funct.
//    - R-type: op2=R2.
//    - addi/slti/lw/sw/beq/bne: sign-extended imm.
//    - andi/ori/muli/lui: zero-extended imm.
//    - sll/srl: shamt.
//    - push: op1=SP, op2=1, sub. pop: op1=SP, op2=1, add.
//  MEMORY strobes:
//    - lw: READ=1, ADDR=ALU. sw: WRITE=1, ADDR=ALU, data=R2.
//    - push: WRITE=1, ADDR=SP, data=R1. pop: READ=1, ADDR=SP+1 (ALU).
//    - All other instructions: strobes 0.
//  WRITEBACK: pc_load=1 always. PC source is chosen as follows:
//    - beq & ZERO=1, or bne & ZERO=0: PC+1+simm.
//    - jr: R1. jmp/jal: {6'b0, IR[25:0]}.
//    - Otherwise: PC+1.
//  WRITEBACK register and stack writes:
//    - reg_w=1 for R-type (except jr), addi, muli, andi, ori, slti, lui, lw, pop and jal.
//    - Write address: rd (R-type), rt (I-type, lw, pop), r31 (jal).
//    - Write data: ALU; mem (lw, pop); {imm, 16'b0} (lui); PC+1 (jal).
//    - sp_load=1 for push (in MEMORY exit) and pop (WRITEBACK).
//  READ and WRITE are never both 1. Unknown opcode/funct is a NOP: PC+1, no reg/mem/sp write.
//  ZERO is sampled only in WRITEBACK; the ALU inputs are held stable from EXECUTE.
// TESTING
//  RST=0 for 2 cycles, any state -> CTRL=0, READ=WRITE=0. Release -> FETCH next cycle with READ=1, CTRL[27]=1.
//  add r3,r1,r2 (0x00221820), MEM_WAIT_CYCLES=0 -> 5-cycle period; WRITEBACK: reg_w=1, wa=rd, pc_load=1, PC+1 src.
//  lw r2,4(r1), MEM_WAIT_CYCLES=3 -> FETCH and MEMORY each last 4 cycles. READ=1 throughout both; total 11 cycles.
//  beq with ZERO=1 -> branch source selected. ZERO=0 -> PC+1. bne gives the inverse, checked in WRITEBACK only.
//  jal 0x0000100 -> reg_w=1, wa=31, wd=PC+1, PC src={6'b0, IR[25:0]}.
//    - push then pop -> WRITE/READ at SP with sp_load each time.
//  RST=0 asserted during EXECUTE of sw -> RESET next edge; WRITE never asserts; restart from FETCH.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// Control-word and memory-strobe bundle between cpu_control_unit (master) and the data path
// plus memory (slave).
interface cpu_control_unit_if;
   logic [31:0] instruction;
   logic        zero;
   logic [31:0] ctrl;
   logic        read;
   logic        write;

   modport master (
      input  instruction,
      input  zero,
      output ctrl,
      output read,
      output write
   );

   modport slave (
      output instruction,
      output zero,
      input  ctrl,
      input  read,
      input  write
   );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the cs147sec05 processor: decodes the IR and ZERO flag into the
// data-path control word and memory strobes, one instruction per FETCH..WRITEBACK pass.
module cpu_control_unit #(
   parameter int unsigned MEM_WAIT_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst,
   cpu_control_unit_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_MULI  = 6'h1d;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_PUSH  = 6'h1b;
   localparam logic [5:0] OP_POP   = 6'h1c;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_MUL = 6'h2c;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [5:0] ALU_NONE = 6'd0;
   localparam logic [5:0] ALU_ADD  = 6'd1;
   localparam logic [5:0] ALU_SUB  = 6'd2;
   localparam logic [5:0] ALU_MUL  = 6'd3;
   localparam logic [5:0] ALU_SHR  = 6'd4;
   localparam logic [5:0] ALU_SHL  = 6'd5;
   localparam logic [5:0] ALU_AND  = 6'd6;
   localparam logic [5:0] ALU_OR   = 6'd7;
   localparam logic [5:0] ALU_NOR  = 6'd8;
   localparam logic [5:0] ALU_SLT  = 6'd9;

   localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT_CYCLES);

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK
   } state_t;

   typedef enum logic [2:0] {
      OP2_ZIMM,
      OP2_SIMM,
      OP2_R2,
      OP2_SHAMT,
      OP2_ONE
   } op2_src_t;

   typedef struct packed {
      logic [2:0] reserved;
      logic       md_sel_1;
      logic       ma_sel_2;
      logic       ma_sel_1;
      logic [5:0] alu_oprn;
      logic       op2_sel_4;
      logic       op2_sel_3;
      logic       op2_sel_2;
      logic       op2_sel_1;
      logic       op1_sel_1;
      logic       sp_load;
      logic       wd_sel_3;
      logic       wd_sel_2;
      logic       wd_sel_1;
      logic       wa_sel_3;
      logic       wa_sel_2;
      logic       wa_sel_1;
      logic       reg_w;
      logic       reg_r;
      logic       r1_sel_1;
      logic       ir_load;
      logic       pc_sel_3;
      logic       pc_sel_2;
      logic       pc_sel_1;
      logic       pc_load;
   } ctrl_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] wait_cnt;
   logic [3:0] wait_next;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_ir_fields;

   logic [5:0] dec_alu;
   op2_src_t   dec_op2;
   logic       dec_op1_sp;
   logic       dec_r1_zero;
   logic       dec_mem_rd;
   logic       dec_mem_wr;
   logic       dec_addr_sp;
   logic       dec_md_r1;
   logic       dec_reg_wr;
   logic       dec_wa_rt;
   logic       dec_wa_r31;
   logic       dec_wd_mem;
   logic       dec_wd_lui;
   logic       dec_wd_pc;
   logic       dec_pc_r1;
   logic       dec_pc_jump;
   logic       dec_beq;
   logic       dec_bne;
   logic       dec_sp_mem;
   logic       dec_sp_wb;
   logic       branch_taken;

   ctrl_t      ctrl_word;
   logic       read_strobe;
   logic       write_strobe;

   assign opcode           = bus.instruction[31:26];
   assign funct            = bus.instruction[5:0];
   assign unused_ir_fields = ^bus.instruction[25:6];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_RESET;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   // FETCH and MEMORY reload the wait counter on entry and hold until it has counted down to zero.
   always_comb begin
      state_next = state;
      case (state)
         S_RESET:     state_next = S_FETCH;
         S_FETCH:     if (wait_cnt == 4'd0) state_next = S_DECODE;
         S_DECODE:    state_next = S_EXECUTE;
         S_EXECUTE:   state_next = S_MEMORY;
         S_MEMORY:    if (wait_cnt == 4'd0) state_next = S_WRITEBACK;
         S_WRITEBACK: state_next = S_FETCH;
         default:     state_next = S_RESET;
      endcase

      wait_next = 4'd0;
      if ((state_next != state) && ((state_next == S_FETCH) || (state_next == S_MEMORY)))
         wait_next = WAIT_LOAD;
      else if (wait_cnt != 4'd0)
         wait_next = wait_cnt - 4'd1;
   end

   always_comb begin
      dec_alu     = ALU_NONE;
      dec_op2     = OP2_ZIMM;
      dec_op1_sp  = 1'b0;
      dec_r1_zero = 1'b0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_addr_sp = 1'b0;
      dec_md_r1   = 1'b0;
      dec_reg_wr  = 1'b0;
      dec_wa_rt   = 1'b0;
      dec_wa_r31  = 1'b0;
      dec_wd_mem  = 1'b0;
      dec_wd_lui  = 1'b0;
      dec_wd_pc   = 1'b0;
      dec_pc_r1   = 1'b0;
      dec_pc_jump = 1'b0;
      dec_beq     = 1'b0;
      dec_bne     = 1'b0;
      dec_sp_mem  = 1'b0;
      dec_sp_wb   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin dec_alu = ALU_ADD; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_SUB: begin dec_alu = ALU_SUB; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_MUL: begin dec_alu = ALU_MUL; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_AND: begin dec_alu = ALU_AND; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_OR:  begin dec_alu = ALU_OR;  dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_NOR: begin dec_alu = ALU_NOR; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_SLT: begin dec_alu = ALU_SLT; dec_op2 = OP2_R2;    dec_reg_wr = 1'b1; end
               FN_SLL: begin dec_alu = ALU_SHL; dec_op2 = OP2_SHAMT; dec_reg_wr = 1'b1; end
               FN_SRL: begin dec_alu = ALU_SHR; dec_op2 = OP2_SHAMT; dec_reg_wr = 1'b1; end
               FN_JR:  begin dec_op2 = OP2_R2;  dec_pc_r1 = 1'b1; end
               default: ;
            endcase
         end
         OP_ADDI: begin dec_alu = ALU_ADD; dec_op2 = OP2_SIMM; dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; end
         OP_SLTI: begin dec_alu = ALU_SLT; dec_op2 = OP2_SIMM; dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; end
         OP_MULI: begin dec_alu = ALU_MUL; dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; end
         OP_ANDI: begin dec_alu = ALU_AND; dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; end
         OP_ORI:  begin dec_alu = ALU_OR;  dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; end
         OP_LUI:  begin dec_reg_wr = 1'b1; dec_wa_rt = 1'b1; dec_wd_lui = 1'b1; end
         OP_BEQ:  begin dec_alu = ALU_SUB; dec_op2 = OP2_SIMM; dec_beq = 1'b1; end
         OP_BNE:  begin dec_alu = ALU_SUB; dec_op2 = OP2_SIMM; dec_bne = 1'b1; end
         OP_LW: begin
            dec_alu    = ALU_ADD;
            dec_op2    = OP2_SIMM;
            dec_mem_rd = 1'b1;
            dec_reg_wr = 1'b1;
            dec_wa_rt  = 1'b1;
            dec_wd_mem = 1'b1;
         end
         OP_SW:   begin dec_alu = ALU_ADD; dec_op2 = OP2_SIMM; dec_mem_wr = 1'b1; end
         OP_JMP:  dec_pc_jump = 1'b1;
         OP_JAL:  begin dec_pc_jump = 1'b1; dec_reg_wr = 1'b1; dec_wa_r31 = 1'b1; dec_wd_pc = 1'b1; end
         // push carries no register field, so R1 is steered to r0 for the stored data.
         OP_PUSH: begin
            dec_alu     = ALU_SUB;
            dec_op2     = OP2_ONE;
            dec_op1_sp  = 1'b1;
            dec_r1_zero = 1'b1;
            dec_mem_wr  = 1'b1;
            dec_addr_sp = 1'b1;
            dec_md_r1   = 1'b1;
            dec_sp_mem  = 1'b1;
         end
         OP_POP: begin
            dec_alu    = ALU_ADD;
            dec_op2    = OP2_ONE;
            dec_op1_sp = 1'b1;
            dec_mem_rd = 1'b1;
            dec_reg_wr = 1'b1;
            dec_wa_rt  = 1'b1;
            dec_wd_mem = 1'b1;
            dec_sp_wb  = 1'b1;
         end
         default: ;
      endcase
   end

   assign branch_taken = (dec_beq & bus.zero) | (dec_bne & ~bus.zero);

   // ALU operand selects stay asserted from EXECUTE through WRITEBACK so the result is stable.
   always_comb begin
      ctrl_word    = '0;
      read_strobe  = 1'b0;
      write_strobe = 1'b0;
      case (state)
         S_FETCH: begin
            read_strobe        = 1'b1;
            ctrl_word.ma_sel_2 = 1'b1;
         end
         S_DECODE: begin
            read_strobe        = 1'b1;
            ctrl_word.ma_sel_2 = 1'b1;
            ctrl_word.ir_load  = 1'b1;
            ctrl_word.reg_r    = 1'b1;
         end
         S_EXECUTE, S_MEMORY, S_WRITEBACK: begin
            ctrl_word.reg_r     = 1'b1;
            ctrl_word.r1_sel_1  = dec_r1_zero;
            ctrl_word.op1_sel_1 = dec_op1_sp;
            ctrl_word.alu_oprn  = dec_alu;
            ctrl_word.op2_sel_4 = (dec_op2 == OP2_R2);
            ctrl_word.op2_sel_3 = (dec_op2 == OP2_SHAMT) || (dec_op2 == OP2_ONE);
            ctrl_word.op2_sel_2 = (dec_op2 == OP2_SIMM);
            ctrl_word.op2_sel_1 = (dec_op2 == OP2_SHAMT);
            if (state == S_MEMORY) begin
               read_strobe        = dec_mem_rd;
               write_strobe       = dec_mem_wr;
               ctrl_word.ma_sel_1 = dec_addr_sp;
               ctrl_word.md_sel_1 = dec_md_r1;
               ctrl_word.sp_load  = dec_sp_mem && (wait_cnt == 4'd0);
            end
            if (state == S_WRITEBACK) begin
               ctrl_word.pc_load  = 1'b1;
               ctrl_word.pc_sel_1 = ~dec_pc_jump & ~dec_pc_r1;
               ctrl_word.pc_sel_2 = ~dec_pc_jump & ~dec_pc_r1 & branch_taken;
               ctrl_word.pc_sel_3 = ~dec_pc_jump;
               ctrl_word.reg_w    = dec_reg_wr;
               ctrl_word.sp_load  = dec_sp_wb;
               if (dec_reg_wr) begin
                  ctrl_word.wa_sel_1 = dec_wa_rt;
                  ctrl_word.wa_sel_2 = dec_wa_r31;
                  ctrl_word.wa_sel_3 = ~dec_wa_r31;
                  ctrl_word.wd_sel_1 = dec_wd_mem;
                  ctrl_word.wd_sel_2 = dec_wd_lui;
                  ctrl_word.wd_sel_3 = ~dec_wd_pc;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.ctrl  = ctrl_word;
   assign bus.read  = read_strobe;
   assign bus.write = write_strobe;

endmodule
